// File: rtl/neo_clk_pkg.sv
// Shared types, default constants and helpers for the NeoGeo clock-enable generator.
package neo_clk_pkg;
   typedef enum logic [1:0] {TICK_NONE, TICK_P, TICK_N} tick_t;

   localparam int unsigned NEO_ACC_W   = 32;
   localparam int unsigned NEO_DIV_W   = 3;
   localparam logic [2:0]  NEO_DIV_RST = 3'b100;
   localparam int unsigned NEO_HB_TAP  = 2;
   localparam int unsigned MASK_W      = 32;

   // Bit k is set when every divider bit below k is 1, i.e. bit k flips on the next increment.
   function automatic logic [MASK_W-1:0] tap_mask(input logic [MASK_W-1:0] div);
      logic [MASK_W-1:0] m;
      m[0] = 1'b1;
      for (int unsigned k = 1; k < MASK_W; k++) m[k] = m[k-1] & div[k-1];
      return m;
   endfunction
endpackage

// File: rtl/neo_clk_if.sv
// Control inputs and clock-enable outputs of the NeoGeo clock generator.
interface neo_clk_if
   import neo_clk_pkg::*;
#(
   parameter int unsigned DIV_W = NEO_DIV_W
) ();
   logic             PAUSE;
   logic             TURBO;
   logic             CLK_EN_24M_P;
   logic             CLK_EN_24M_N;
   logic [DIV_W-1:0] CLK_DIV;
   logic [DIV_W-1:0] EN_DIV_P;
   logic [DIV_W-1:0] EN_DIV_N;
   logic             CLK_68KCLK;
   logic             EN_68K_P;
   logic             EN_68K_N;
   logic             CLK_1HB;
   logic             EN_1HB;

   modport master (
      input  PAUSE, TURBO,
      output CLK_EN_24M_P, CLK_EN_24M_N, CLK_DIV, EN_DIV_P, EN_DIV_N,
             CLK_68KCLK, EN_68K_P, EN_68K_N, CLK_1HB, EN_1HB
   );

   modport slave (
      output PAUSE, TURBO,
      input  CLK_EN_24M_P, CLK_EN_24M_N, CLK_DIV, EN_DIV_P, EN_DIV_N,
             CLK_68KCLK, EN_68K_P, EN_68K_N, CLK_1HB, EN_1HB
   );
endinterface

// File: rtl/neo_phase_acc.sv
// Fractional phase accumulator producing alternating registered 24M P/N half-period ticks.
module neo_phase_acc
   import neo_clk_pkg::*;
#(
   parameter int unsigned      ACC_W     = NEO_ACC_W,
   parameter logic [ACC_W-1:0] PHASE_INC = ACC_W'(32'h8000_0000)
) (
   input  logic CLK,
   input  logic nRESETP,
   input  logic PAUSE,
   output logic tick_p,
   output logic tick_n
);
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;
   logic             phase_n;
   tick_t            tick_q;

   assign sum = {1'b0, acc} + {1'b0, PHASE_INC};

   // While paused everything holds, including a pending tick, so time simply freezes.
   always_ff @(posedge CLK or negedge nRESETP) begin
      if (!nRESETP) begin
         acc     <= '0;
         phase_n <= 1'b0;
         tick_q  <= TICK_NONE;
      end else if (!PAUSE) begin
         acc <= sum[ACC_W-1:0];
         if (sum[ACC_W]) begin
            tick_q  <= phase_n ? TICK_N : TICK_P;
            phase_n <= ~phase_n;
         end else begin
            tick_q  <= TICK_NONE;
         end
      end
   end

   assign tick_p = (tick_q == TICK_P);
   assign tick_n = (tick_q == TICK_N);
endmodule

// File: rtl/neo_clocks_gen.sv
// NeoGeo clock-enable generator: 24M ticks, divider chain with per-tap edges, 68K clock and 1HB.
module neo_clocks_gen
   import neo_clk_pkg::*;
#(
   parameter int unsigned      ACC_W     = NEO_ACC_W,
   parameter logic [ACC_W-1:0] PHASE_INC = ACC_W'(32'h8000_0000),
   parameter int unsigned      DIV_W     = NEO_DIV_W,
   parameter logic [DIV_W-1:0] DIV_RST   = DIV_W'(NEO_DIV_RST),
   parameter int unsigned      HB_TAP    = NEO_HB_TAP
) (
   input  logic     CLK,
   input  logic     nRESETP,
   neo_clk_if.master bus
);
   logic             tick_p_q, tick_n_q;
   logic             tick_p_c, tick_n_c;
   logic [DIV_W-1:0] clk_div;
   logic [DIV_W-1:0] carry_mask_c;
   logic [DIV_W-1:0] en_div_p_c, en_div_n_c;
   logic             clk_68k, turbo_q, clk_1hb;
   logic             toggle_68k_c, en_1hb_c;

   neo_phase_acc #(
      .ACC_W     (ACC_W),
      .PHASE_INC (PHASE_INC)
   ) u_phase_acc (
      .CLK     (CLK),
      .nRESETP (nRESETP),
      .PAUSE   (bus.PAUSE),
      .tick_p  (tick_p_q),
      .tick_n  (tick_n_q)
   );

   // A tick held across a pause stays invisible until release.
   assign tick_p_c = tick_p_q & ~bus.PAUSE;
   assign tick_n_c = tick_n_q & ~bus.PAUSE;

   assign carry_mask_c = DIV_W'(tap_mask(MASK_W'(clk_div)));
   assign en_div_p_c   = {DIV_W{tick_n_c}} & carry_mask_c & ~clk_div;
   assign en_div_n_c   = {DIV_W{tick_n_c}} & carry_mask_c &  clk_div;

   assign toggle_68k_c = tick_p_c | (tick_n_c & turbo_q);
   assign en_1hb_c     = tick_n_c & (clk_div[HB_TAP:0] == '0);

   // TURBO is only taken on a 68K falling edge so a rate change never shortens a phase.
   always_ff @(posedge CLK or negedge nRESETP) begin
      if (!nRESETP) begin
         clk_div <= DIV_RST;
         clk_68k <= 1'b0;
         turbo_q <= 1'b0;
         clk_1hb <= 1'b0;
      end else begin
         if (tick_n_c) clk_div <= clk_div + DIV_W'(1);
         if (toggle_68k_c) begin
            clk_68k <= ~clk_68k;
            if (clk_68k) turbo_q <= bus.TURBO;
         end
         if (en_div_p_c[0]) clk_1hb <= ~clk_div[HB_TAP];
      end
   end

   assign bus.CLK_EN_24M_P = tick_p_c;
   assign bus.CLK_EN_24M_N = tick_n_c;
   assign bus.CLK_DIV      = clk_div;
   assign bus.EN_DIV_P     = en_div_p_c;
   assign bus.EN_DIV_N     = en_div_n_c;
   assign bus.CLK_68KCLK   = clk_68k;
   assign bus.EN_68K_P     = toggle_68k_c & ~clk_68k;
   assign bus.EN_68K_N     = toggle_68k_c &  clk_68k;
   assign bus.CLK_1HB      = clk_1hb;
   assign bus.EN_1HB       = en_1hb_c;
endmodule
